// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write to $4014 halts the CPU and copies one 256-byte page to $2004.
// Optional odd-cycle alignment state is compiled in with OAM_DMA_ALIGN_EN.
module oam_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_rdata,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        rdy_q, rdy_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic        dma_rw_q, dma_rw_d;
    logic [7:0]  dma_wdata_q, dma_wdata_d;
`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b1;
            dma_active_q <= 1'b0;
            dma_addr_q   <= 16'h0000;
            dma_rw_q     <= 1'b1;
            dma_wdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            dma_active_q <= dma_active_d;
            dma_addr_q   <= dma_addr_d;
            dma_rw_q     <= dma_rw_d;
            dma_wdata_q  <= dma_wdata_d;
        end
`ifdef OAM_DMA_ALIGN_EN
        parity_q <= reset ? 1'b0 : parity_d;
`endif
        page_q  <= page_d;
        idx_q   <= idx_d;
        latch_q <= latch_d;
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
`ifdef OAM_DMA_ALIGN_EN
        parity_d = ~parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_addr == 16'h4014 && !cpu_rw) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            // The 6502 ignores RDY on write cycles, so wait for a read before taking the bus.
            S_HALT: begin
                if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = parity_q ? S_ALIGN : S_READ;
`else
                    state_d = S_READ;
`endif
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: state_d = S_READ;
`endif
            S_READ: begin
                latch_d = bus_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                idx_d   = idx_q + 8'h01;
                state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        rdy_d        = 1'b1;
        dma_active_d = 1'b0;
        dma_addr_d   = dma_addr_q;
        dma_rw_d     = 1'b1;
        dma_wdata_d  = dma_wdata_q;
        case (state_d)
            S_HALT: rdy_d = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: rdy_d = 1'b0;
`endif
            S_READ: begin
                rdy_d        = 1'b0;
                dma_active_d = 1'b1;
                dma_addr_d   = {page_d, idx_d};
            end
            S_WRITE: begin
                rdy_d        = 1'b0;
                dma_active_d = 1'b1;
                dma_addr_d   = 16'h2004;
                dma_rw_d     = 1'b0;
                dma_wdata_d  = latch_d;
            end
            default: ;
        endcase
    end

    assign rdy        = rdy_q;
    assign dma_active = dma_active_q;
    assign dma_addr   = dma_addr_q;
    assign dma_rw     = dma_rw_q;
    assign dma_wdata  = dma_wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma; bus memory returns addr[7:0]^addr[15:8] so page errors show in data.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic [7:0]  bus_rdata;
    logic        rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    oam_dma dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rw(cpu_rw), .bus_rdata(bus_rdata), .rdy(rdy), .dma_active(dma_active),
        .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_wdata(dma_wdata)
    );

    always #5 clk = ~clk;

    assign bus_rdata = dma_addr[7:0] ^ dma_addr[15:8];

    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [7:0]  exp_page = 8'h00;
    logic        clr = 1'b0;
    int rdy_low, halt_cyc, rd_cnt, wr_cnt, rd_err, wr_err, bad_rw, halt_par;
    logic        par_seen;
    logic [15:0] last_rd;

    always @(negedge clk) begin
        if (clr) begin
            rdy_low <= 0; halt_cyc <= 0; rd_cnt <= 0; wr_cnt <= 0;
            rd_err <= 0; wr_err <= 0; bad_rw <= 0; halt_par <= 0;
            par_seen <= 1'b0; last_rd <= 16'h0000;
        end else begin
            if (!rdy) rdy_low <= rdy_low + 1;
            if (!rdy && !dma_active) begin
                halt_cyc <= halt_cyc + 1;
                if (cpu_rw && !par_seen) begin
                    par_seen <= 1'b1;
                    halt_par <= cyc & 1;
                end
            end
            if (dma_active && dma_rw) begin
                if (dma_addr !== {exp_page, 8'(rd_cnt)}) rd_err <= rd_err + 1;
                rd_cnt  <= rd_cnt + 1;
                last_rd <= dma_addr;
            end
            if (dma_active && !dma_rw) begin
                if (dma_addr !== 16'h2004 || dma_wdata !== (8'(wr_cnt) ^ exp_page)) wr_err <= wr_err + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (!dma_active && !dma_rw) bad_rw <= bad_rw + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    // par_want < 0: no parity constraint on the HALT cycle
    task automatic trigger(input logic [7:0] pg, input int stall, input int par_want);
        exp_page = pg;
        clear_stats();
        @(posedge clk); #1;
        if (par_want >= 0 && ((cyc + 1) & 1) != par_want) begin
            @(posedge clk); #1;
        end
        cpu_addr = 16'h4014; cpu_wdata = pg; cpu_rw = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        cpu_rw = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!rdy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'd0, rdy}, 32'd1);
    endtask

    task automatic wait_writes(input int cnt, input string tag);
        int n;
        n = 0;
        while (wr_cnt < cnt && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, wr_cnt, cnt);
    endtask

    function automatic int align_extra();
`ifdef OAM_DMA_ALIGN_EN
        return halt_par;
`else
        return 0;
`endif
    endfunction

    initial begin
        int w;
        reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy",    {31'd0, rdy},        32'd1);
        check("rst_active", {31'd0, dma_active}, 32'd0);
        check("rst_addr",   {16'd0, dma_addr},   32'h0000);
        check("rst_rw",     {31'd0, dma_rw},     32'd1);
        check("rst_wdata",  {24'd0, dma_wdata},  32'h00);

        // Trigger and reset on the same edge: reset must win
        cpu_addr = 16'h4014; cpu_wdata = 8'h33; cpu_rw = 1'b0;
        @(posedge clk); #1;
        check("rstwin_rdy", {31'd0, rdy}, 32'd1);
        reset = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rw = 1'b1;
        @(posedge clk); #1;
        check("rstwin_rdy2",   {31'd0, rdy},        32'd1);
        check("rstwin_active", {31'd0, dma_active}, 32'd0);

        // Basic copy of page $02
        trigger(8'h02, 0, -1);
        check("basic_rdy_now", {31'd0, rdy}, 32'd0);
        wait_done("basic_done");
        check("basic_rdy_low", rdy_low,  513 + align_extra());
        check("basic_halt",    halt_cyc, 1 + align_extra());
        check("basic_wr_cnt",  wr_cnt,   256);
        check("basic_rd_cnt",  rd_cnt,   256);
        check("basic_wr_err",  wr_err,   0);
        check("basic_rd_err",  rd_err,   0);
        check("basic_bad_rw",  bad_rw,   0);
        check("basic_last_rd", {16'd0, last_rd}, 32'h02FF);
        check("basic_idle_active", {31'd0, dma_active}, 32'd0);
        check("basic_idle_rw",     {31'd0, dma_rw},     32'd1);
        check("basic_idle_addr",   {16'd0, dma_addr},   32'h2004);

        // CPU on write cycles for 3 cycles after the trigger
        trigger(8'h10, 3, -1);
        wait_done("stall_done");
        check("stall_halt",    halt_cyc, 4 + align_extra());
        check("stall_rdy_low", rdy_low,  516 + align_extra());
        check("stall_wr_err",  wr_err,   0);
        check("stall_rd_err",  rd_err,   0);

        // Retrigger to $05 while page $03 is in flight
        trigger(8'h03, 0, -1);
        wait_writes(10, "retrig_reach10");
        cpu_addr = 16'h4014; cpu_wdata = 8'h05; cpu_rw = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rw = 1'b1;
        wait_done("retrig_done");
        check("retrig_rd_err", rd_err, 0);
        check("retrig_wr_err", wr_err, 0);
        check("retrig_wr_cnt", wr_cnt, 256);
        repeat (20) @(posedge clk);
        #1;
        check("retrig_no_second_rd", rd_cnt, 256);
        check("retrig_rdy",          {31'd0, rdy}, 32'd1);

        // Reset after 100 writes aborts the copy
        trigger(8'h04, 0, -1);
        wait_writes(100, "abort_reach100");
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_rdy",    {31'd0, rdy},        32'd1);
        check("abort_active", {31'd0, dma_active}, 32'd0);
        check("abort_rw",     {31'd0, dma_rw},     32'd1);
        check("abort_addr",   {16'd0, dma_addr},   32'h0000);
        check("abort_wdata",  {24'd0, dma_wdata},  32'h00);
        reset = 1'b0;
        w = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_more_wr", wr_cnt, w);
        check("abort_wr_total",   wr_cnt, 100);
        check("abort_still_rdy",  {31'd0, rdy}, 32'd1);

        // Page $FF ends at $FFFF without touching $0000
        trigger(8'hFF, 0, -1);
        wait_done("wrap_done");
        check("wrap_last_rd", {16'd0, last_rd}, 32'hFFFF);
        check("wrap_rd_err",  rd_err, 0);
        check("wrap_wr_err",  wr_err, 0);
        check("wrap_wr_cnt",  wr_cnt, 256);
        repeat (10) @(posedge clk);
        #1;
        check("wrap_no_extra_rd", rd_cnt, 256);

`ifdef OAM_DMA_ALIGN_EN
        trigger(8'h06, 0, 0);
        wait_done("par0_done");
        check("par0_seen",    halt_par, 0);
        check("par0_rdy_low", rdy_low,  513);
        check("par0_wr_err",  wr_err,   0);
        trigger(8'h07, 0, 1);
        wait_done("par1_done");
        check("par1_seen",    halt_par, 1);
        check("par1_rdy_low", rdy_low,  514);
        check("par1_wr_err",  wr_err,   0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
